// File: rtl/btb_pkg.sv
// Shared types, counter encodings and address-split helpers for the branch target buffer.
package btb_pkg;

  localparam int PC_MAX          = 64;
  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_PC_WIDTH    = 64;
  localparam int DEF_TAG_BITS    = DEF_PC_WIDTH - 2 - DEF_INDEX_BITS;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  // Entry layout for the default geometry; the top re-derives it for other widths.
  typedef struct packed {
    logic                      valid;
    logic [DEF_TAG_BITS-1:0]   tag;
    logic [DEF_PC_WIDTH-1:0]   target;
    logic [1:0]                ctr;
  } btb_entry_t;

  // Word index: pc[index_bits+1:2], returned zero-extended.
  function automatic logic [PC_MAX-1:0] btb_index(input logic [PC_MAX-1:0] pc,
                                                 input int index_bits);
    return (pc >> 2) & ((PC_MAX'(1) << index_bits) - PC_MAX'(1));
  endfunction

  // Tag: everything above the index field.
  function automatic logic [PC_MAX-1:0] btb_tag(input logic [PC_MAX-1:0] pc,
                                               input int index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down direction counter.
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup from the fetch PC, per-cycle training from EX.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc_if,
  input  logic [PC_WIDTH-1:0] pc_ex,
  input  logic                branch_taken_ex,
  input  logic [PC_WIDTH-1:0] target_addr_ex,
  output logic [PC_WIDTH-1:0] predicted_target,
  output logic                hit
);

  localparam int TAG_BITS = PC_WIDTH - 2 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          ctr;
  } entry_t;

  // Flop array on purpose: lookup must be readable in the same cycle.
  entry_t entries_q [ENTRIES];

  logic [INDEX_BITS-1:0] idx_if, idx_ex;
  logic [TAG_BITS-1:0]   tag_if, tag_ex;
  entry_t                rd_if, rd_ex, entry_d;
  logic                  match_if, match_ex, write_ex;
  logic [1:0]            ctr_next;

  assign idx_if = INDEX_BITS'(btb_index(PC_MAX'(pc_if), INDEX_BITS));
  assign idx_ex = INDEX_BITS'(btb_index(PC_MAX'(pc_ex), INDEX_BITS));
  assign tag_if = TAG_BITS'(btb_tag(PC_MAX'(pc_if), INDEX_BITS));
  assign tag_ex = TAG_BITS'(btb_tag(PC_MAX'(pc_ex), INDEX_BITS));

  assign rd_if    = entries_q[idx_if];
  assign rd_ex    = entries_q[idx_ex];
  assign match_if = rd_if.valid && (rd_if.tag == tag_if);
  assign match_ex = rd_ex.valid && (rd_ex.tag == tag_ex);

  // Gated by reset so outputs are clean before the first clock edge clears valids.
  assign hit              = !reset && match_if && rd_if.ctr[1];
  assign predicted_target = hit ? rd_if.target : '0;

  sat_counter2 u_ctr (
    .ctr_i (rd_ex.ctr),
    .up_i  (branch_taken_ex),
    .ctr_o (ctr_next)
  );

  always_comb begin
    entry_d  = rd_ex;
    write_ex = 1'b0;
    if (branch_taken_ex) begin
      write_ex = 1'b1;
      if (match_ex) begin
        entry_d.target = target_addr_ex;
        entry_d.ctr    = ctr_next;
      end else begin
        entry_d.valid  = 1'b1;
        entry_d.tag    = tag_ex;
        entry_d.target = target_addr_ex;
        entry_d.ctr    = WEAK_T;
      end
    end else if (match_ex) begin
      write_ex    = 1'b1;
      entry_d.ctr = ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].ctr   <= STRONG_NT;
      end
    end else if (write_ex) begin
      entries_q[idx_ex] <= entry_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with a per-cycle reference model.
module tb_branch_target_buffer;

  localparam logic [63:0] IDLE = 64'hFFFF_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_if, pc_ex, target_addr_ex, predicted_target;
  logic        branch_taken_ex, hit;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: a 64-slot table keyed by word index, full tag = pc >> 8.
  bit          m_valid [64];
  logic [63:0] m_tag   [64];
  logic [63:0] m_tgt   [64];
  int          m_ctr   [64];

  branch_target_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .pc_if            (pc_if),
    .pc_ex            (pc_ex),
    .branch_taken_ex  (branch_taken_ex),
    .target_addr_ex   (target_addr_ex),
    .predicted_target (predicted_target),
    .hit              (hit)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  always @(posedge clk) begin
    int i;
    i = idx_of(pc_ex);
    if (reset) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 0;
      end
    end else if (branch_taken_ex) begin
      if (m_valid[i] && m_tag[i] == (pc_ex >> 8)) begin
        m_tgt[i] = target_addr_ex;
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = pc_ex >> 8;
        m_tgt[i]   = target_addr_ex;
        m_ctr[i]   = 2;
      end
    end else if (m_valid[i] && m_tag[i] == (pc_ex >> 8)) begin
      m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
    end
  end

  always @(negedge clk) begin
    int i;
    bit          e_hit;
    logic [63:0] e_tgt;
    if (chk_en) begin
      i     = idx_of(pc_if);
      e_hit = !reset && m_valid[i] && m_tag[i] == (pc_if >> 8) && m_ctr[i] >= 2;
      e_tgt = e_hit ? m_tgt[i] : 64'd0;
      checks++;
      if (hit !== e_hit || predicted_target !== e_tgt) begin
        failures++;
        $display("FAIL model pc_if=%h: got hit=%b tgt=%h, want hit=%b tgt=%h",
                 pc_if, hit, predicted_target, e_hit, e_tgt);
      end
    end
  end

  // One clock cycle with the given inputs; returns at the following negedge.
  task automatic cyc(input logic [63:0] pif, input logic [63:0] pex, input logic tk,
                     input logic [63:0] tgt, input logic rst);
    @(posedge clk);
    #1;
    pc_if = pif; pc_ex = pex; branch_taken_ex = tk; target_addr_ex = tgt; reset = rst;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic e_hit, input logic [63:0] e_tgt);
    checks++;
    if (hit !== e_hit || predicted_target !== e_tgt) begin
      failures++;
      $display("FAIL %s: got hit=%b tgt=%h, want hit=%b tgt=%h",
               name, hit, predicted_target, e_hit, e_tgt);
    end
  endtask

  initial begin
    reset = 1'b1; pc_if = 64'h1000; pc_ex = IDLE; branch_taken_ex = 1'b0; target_addr_ex = '0;
    for (int k = 0; k < 64; k++) begin
      m_valid[k] = 1'b0; m_ctr[k] = 0; m_tag[k] = '0; m_tgt[k] = '0;
    end
    chk_en = 1'b1;

    // 1: reset
    cyc(64'h1000, IDLE, 0, 0, 1);
    lit("in_reset", 0, 0);
    cyc(64'h1000, IDLE, 0, 0, 1);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("after_reset", 0, 0);

    // 2: allocate and predict
    cyc(64'h1000, 64'h1000, 1, 64'h2000, 0);
    lit("alloc_same_cycle", 0, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("alloc_hit", 1, 64'h2000);
    cyc(64'h1004, IDLE, 0, 0, 0);
    lit("neighbour_miss", 0, 0);

    // 3: hysteresis
    cyc(64'h1000, 64'h1000, 1, 64'h2000, 0);
    cyc(64'h1000, 64'h1000, 0, 0, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("ctr2_hit", 1, 64'h2000);
    cyc(64'h1000, 64'h1000, 0, 0, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("ctr1_miss", 0, 0);
    cyc(64'h1000, 64'h1000, 0, 0, 0);
    cyc(64'h1000, 64'h1000, 0, 0, 0);
    cyc(64'h1000, 64'h1000, 1, 64'h2000, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("sat0_then_up", 0, 0);
    cyc(64'h1000, 64'h1000, 1, 64'h2000, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("ctr2_again", 1, 64'h2000);

    // 4: aliasing
    cyc(64'h1000, 64'h1100, 1, 64'h3000, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("evicted", 0, 0);
    cyc(64'h1100, IDLE, 0, 0, 0);
    lit("alias_hit", 1, 64'h3000);
    cyc(64'h1100, 64'h1000, 0, 0, 0);
    cyc(64'h1100, IDLE, 0, 0, 0);
    lit("alias_untouched", 1, 64'h3000);

    // 5: same-cycle read/write, low bits ignored, high tag bits compared
    cyc(64'h4000, 64'h4000, 1, 64'h5000, 0);
    lit("rw_old", 0, 0);
    cyc(64'h4000, IDLE, 0, 0, 0);
    lit("rw_new", 1, 64'h5000);
    cyc(64'h4002, IDLE, 0, 0, 0);
    lit("low_bits", 1, 64'h5000);
    cyc(64'h0000_0001_0000_4000, IDLE, 0, 0, 0);
    lit("high_tag", 0, 0);

    // 6: reset mid-operation beats training
    cyc(64'h1000, 64'h1000, 1, 64'h2000, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("repop_1000", 1, 64'h2000);
    cyc(64'h1100, 64'h1100, 1, 64'h3000, 0);
    cyc(64'h1100, 64'h2000, 1, 64'h7000, 1);
    lit("reset_assert", 0, 0);
    cyc(64'h1000, IDLE, 0, 0, 0);
    lit("post_rst_1000", 0, 0);
    cyc(64'h1100, IDLE, 0, 0, 0);
    lit("post_rst_1100", 0, 0);
    cyc(64'h2000, IDLE, 0, 0, 0);
    lit("post_rst_2000", 0, 0);
    cyc(64'h4000, IDLE, 0, 0, 0);
    lit("post_rst_4000", 0, 0);

    chk_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
